// File: rtl/mux_2to1.sv
// 2:1 word multiplexer with an optional registered output, an output-valid flag
// and a one-cycle pulse whenever the select line changes between edges.
module mux_2to1 #(
    parameter int              WIDTH   = 8,
    parameter bit              REG_OUT = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic             select_mux,
    input  logic             en,
    output logic [WIDTH-1:0] output_mux,
    output logic             out_valid,
    output logic             sel_change
);

    logic [WIDTH-1:0] mux_d;
    logic             sel_q;

    // A continuous assign cannot hold state, so an X on select_mux propagates
    // rather than latching the previous word.
    assign mux_d = select_mux ? input_2 : input_1;

    // Select-change detector runs every edge, independent of the load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            sel_change <= 1'b0;
        end else begin
            // NOTE: non-blocking so sel_change compares against the old sel_q.
            sel_change <= (select_mux != sel_q);
            sel_q      <= select_mux;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] out_q;
            logic             valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q   <= RST_VAL;
                    valid_q <= 1'b0;
                end else if (en) begin
                    out_q   <= mux_d;
                    valid_q <= 1'b1;
                end
            end

            assign output_mux = out_q;
            assign out_valid  = valid_q;
        end else begin : g_comb
            logic en_unused;

            // Combinational build: en has no register to gate.
            assign en_unused  = en;
            assign output_mux = rst_n ? mux_d : RST_VAL;
            assign out_valid  = rst_n;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: registered and combinational builds driven
// side by side with directed and random stimulus against a behavioural model.
module tb_mux_2to1;

    logic       clk;
    logic       rst_n;
    logic [7:0] input_1;
    logic [7:0] input_2;
    logic       select_mux;
    logic       en;
    logic [7:0] out_reg;
    logic       valid_reg;
    logic       change_reg;
    logic [7:0] out_comb;
    logic       valid_comb;
    logic       change_comb;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state for the registered build.
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_change;
    logic       prev_sel;

    mux_2to1 #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(8'h00)) dut_reg (
        .clk(clk), .rst_n(rst_n), .input_1(input_1), .input_2(input_2),
        .select_mux(select_mux), .en(en), .output_mux(out_reg),
        .out_valid(valid_reg), .sel_change(change_reg)
    );

    mux_2to1 #(.WIDTH(8), .REG_OUT(1'b0), .RST_VAL(8'h00)) dut_comb (
        .clk(clk), .rst_n(rst_n), .input_1(input_1), .input_2(input_2),
        .select_mux(select_mux), .en(en), .output_mux(out_comb),
        .out_valid(valid_comb), .sel_change(change_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    task automatic model_reset();
        exp_out    = 8'h00;
        exp_valid  = 1'b0;
        exp_change = 1'b0;
        prev_sel   = 1'b0;
    endtask

    // Apply one set of inputs, let one edge pass, then compare both builds.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic s, input logic e);
        logic [7:0] chosen;
        chosen     = s ? b : a;
        input_1    = a;
        input_2    = b;
        select_mux = s;
        en         = e;
        #1;
        check("comb_out", out_comb, chosen);
        check("comb_valid", valid_comb, 1'b1);
        @(posedge clk);
        if (e) begin
            exp_out   = chosen;
            exp_valid = 1'b1;
        end
        exp_change = (s != prev_sel);
        prev_sel   = s;
        #1;
        check("reg_out", out_reg, exp_out);
        check("reg_valid", valid_reg, exp_valid);
        check("sel_change", change_reg, exp_change);
        check("comb_change", change_comb, exp_change);
    endtask

    initial begin
        rst_n      = 1'b0;
        input_1    = 8'h67;
        input_2    = 8'h60;
        select_mux = 1'b0;
        en         = 1'b1;
        model_reset();

        // Reset with the clock running.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out_reg, 8'h00);
        check("rst_valid", valid_reg, 1'b0);
        check("rst_change", change_reg, 1'b0);
        check("rst_comb_out", out_comb, 8'h00);
        check("rst_comb_valid", valid_comb, 1'b0);
        rst_n = 1'b1;

        // Directed: select 0, select 1 with pulse, pulse ends, hold with en=0.
        step(8'h67, 8'h60, 1'b0, 1'b1);
        step(8'h67, 8'h60, 1'b1, 1'b1);
        step(8'h67, 8'h60, 1'b1, 1'b1);
        step(8'hFF, 8'h60, 1'b0, 1'b0);
        step(8'hFF, 8'h60, 1'b0, 1'b0);
        step(8'hFF, 8'h60, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++)
            step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom % 4) != 0);

        // Asynchronous reset between edges: outputs clear before any edge.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_out", out_reg, 8'h00);
        check("async_valid", valid_reg, 1'b0);
        check("async_change", change_reg, 1'b0);
        check("async_comb_out", out_comb, 8'h00);
        check("async_comb_valid", valid_comb, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // No load yet after reset: valid stays low until en=1.
        step(8'h12, 8'h34, 1'b1, 1'b0);
        step(8'h12, 8'h34, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++)
            step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom % 3) != 0);

        // Combinational build follows a select toggling every 5 time units.
        input_1 = 8'h67;
        input_2 = 8'h60;
        for (int i = 0; i < 8; i++) begin
            select_mux = 1'(i % 2);
            #1;
            check("comb_toggle", out_comb, (i % 2) ? 8'h60 : 8'h67);
            #4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
